// File: rtl/cla_pipe_addsub_if.sv
// Operand/result bus of the pipelined carry-lookahead adder/subtractor.
// The master drives operand beats and the result ready; the slave is the adder.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic             in_cin;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAGW-1:0]  out_tag;
  logic             out_p;

  modport master (
    output in_valid, in_sub, in_cin, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag, out_p
  );

  modport slave (
    input  in_valid, in_sub, in_cin, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag, out_p
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit slice resolved per stage,
// slice carry registered between stages, all result bits leave the pipe together.
module cla_pipe_addsub #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16,
  parameter int TAGW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  cla_pipe_addsub_if.slave   bus
);

  localparam int NSTG = WIDTH / SLICE;
  localparam int NGRP = SLICE / 4;

  if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0) begin : g_bad_params
    $error("cla_pipe_addsub: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
  end

  typedef struct packed {
    logic [SLICE-1:0] sum;
    logic             cout;
  } slice_res_t;

  // Two-level lookahead: bit carries inside each 4-bit group, group carries
  // expanded as sum-of-products over the group (G,P) pairs.
  function automatic slice_res_t cla_slice(input logic [SLICE-1:0] a,
                                           input logic [SLICE-1:0] b,
                                           input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] c;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gc;
    logic             t;
    slice_res_t       res;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    for (int j = 0; j < NGRP; j++) begin
      t = cin;
      for (int m = 0; m < j; m++) t = t & gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (gc[j] & p[4*j]);
      c[4*j+2] = g[4*j+1] | (g[4*j] & p[4*j+1]) | (gc[j] & p[4*j] & p[4*j+1]);
      c[4*j+3] = g[4*j+2] | (g[4*j+1] & p[4*j+2]) | (g[4*j] & p[4*j+1] & p[4*j+2])
               | (gc[j] & p[4*j] & p[4*j+1] & p[4*j+2]);
    end
    res.sum  = p ^ c;
    res.cout = gg[NGRP-1] | (gp[NGRP-1] & gc[NGRP-1]);
    return res;
  endfunction

  // Each stage word rotates right by one slice: the low slice is consumed and its
  // result enters at the top, so the skewed operands and the deskewed result share
  // one register and the last stage holds the full result in natural bit order.
  // The b word is rotated the same way, trading b' for the per-bit propagates.
  logic [WIDTH-1:0] d_in   [NSTG];
  logic [WIDTH-1:0] pb_in  [NSTG];
  logic             c_in   [NSTG];
  logic             v_in   [NSTG];
  logic [TAGW-1:0]  tag_in [NSTG];
  slice_res_t       r      [NSTG];
  logic [WIDTH-1:0] d_nxt  [NSTG];
  logic [WIDTH-1:0] pb_nxt [NSTG];
  logic [WIDTH-1:0] d_q    [NSTG];
  logic [WIDTH-1:0] pb_q   [NSTG];
  logic             c_q    [NSTG];
  logic             v_q    [NSTG];
  logic [TAGW-1:0]  tag_q  [NSTG];
  logic             en;

  assign en           = ~v_q[NSTG-1] | bus.out_ready;
  assign bus.in_ready = en;

  assign d_in[0]   = bus.in_a;
  assign pb_in[0]  = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c_in[0]   = bus.in_sub | bus.in_cin;
  assign v_in[0]   = bus.in_valid;
  assign tag_in[0] = bus.in_tag;

  for (genvar k = 1; k < NSTG; k++) begin : g_link
    assign d_in[k]   = d_q[k-1];
    assign pb_in[k]  = pb_q[k-1];
    assign c_in[k]   = c_q[k-1];
    assign v_in[k]   = v_q[k-1];
    assign tag_in[k] = tag_q[k-1];
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    assign r[k] = cla_slice(d_in[k][SLICE-1:0], pb_in[k][SLICE-1:0], c_in[k]);
    if (NSTG == 1) begin : g_single
      assign d_nxt[k]  = r[k].sum;
      assign pb_nxt[k] = d_in[k] ^ pb_in[k];
    end else begin : g_rot
      assign d_nxt[k]  = {r[k].sum, d_in[k][WIDTH-1:SLICE]};
      assign pb_nxt[k] = {d_in[k][SLICE-1:0] ^ pb_in[k][SLICE-1:0], pb_in[k][WIDTH-1:SLICE]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too (not only the valid bits)
      // because the result outputs must read zero straight out of reset.
      for (int k = 0; k < NSTG; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        d_q[k]   <= '0;
        pb_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < NSTG; k++) begin
        v_q[k]   <= v_in[k];
        c_q[k]   <= r[k].cout;
        d_q[k]   <= d_nxt[k];
        pb_q[k]  <= pb_nxt[k];
        tag_q[k] <= tag_in[k];
      end
    end
  end

  assign bus.out_valid = v_q[NSTG-1];
  assign bus.out_sum   = d_q[NSTG-1];
  assign bus.out_cout  = c_q[NSTG-1];
  assign bus.out_tag   = tag_q[NSTG-1];
  assign bus.out_p     = &pb_q[NSTG-1];
  // Carry into the MSB is recovered as sum ^ propagate at that bit.
  assign bus.out_ovf   = d_q[NSTG-1][WIDTH-1] ^ pb_q[NSTG-1][WIDTH-1] ^ c_q[NSTG-1];

endmodule
